lamp_safety_monitor: RTL and testbench

//  Downstream of the two per-direction traffic FSMs (E and N). Registers their car/walker lamp codes to the pins.

---
 rtl/lamp_safety_monitor_pkg.sv | 51 +++++
 rtl/lamp_blink_tick.sv | 35 +++
 rtl/lamp_safety_monitor.sv | 105 ++++++++++
 tb/tb_lamp_safety_monitor.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lamp_safety_monitor_pkg.sv
// Shared lamp encodings, fault causes and monitor states for the lamp safety monitor.
// violation_code() ranks the checks on the current lamp codes; the lowest code has the highest priority.
package lamp_safety_monitor_pkg;

    localparam logic [3:0] C_NONE   = 4'b0000;
    localparam logic [3:0] C_GREEN  = 4'b0001;
    localparam logic [3:0] C_LEFT   = 4'b0010;
    localparam logic [3:0] C_YELLOW = 4'b0100;
    localparam logic [3:0] C_RED    = 4'b1000;

    localparam logic [1:0] W_NONE    = 2'b00;
    localparam logic [1:0] W_GREEN   = 2'b01;
    localparam logic [1:0] W_RED     = 2'b10;
    localparam logic [1:0] W_ILLEGAL = 2'b11;

    localparam logic [2:0] F_NONE      = 3'd0;
    localparam logic [2:0] F_CROSS_CAR = 3'd1;
    localparam logic [2:0] F_E_WALK    = 3'd2;
    localparam logic [2:0] F_N_WALK    = 3'd3;
    localparam logic [2:0] F_ILLEGAL   = 3'd4;

    typedef enum logic [1:0] {
        MONITOR         = 2'd0,
        FAULT_HOLD      = 2'd1,
        FAULT_CLEARABLE = 2'd2
    } monitor_state_t;

    function automatic logic car_moving(input logic [3:0] ct);
        return (ct == C_GREEN) || (ct == C_LEFT) || (ct == C_YELLOW);
    endfunction

    // A one-hot or zero code clears its lowest set bit to zero.
    function automatic logic car_illegal(input logic [3:0] ct);
        return (ct & (ct - 4'd1)) != 4'd0;
    endfunction

    function automatic logic [2:0] violation_code(input logic [3:0] e_ct, input logic [1:0] e_wt,
                                                  input logic [3:0] n_ct, input logic [1:0] n_wt);
        if (car_moving(e_ct) && car_moving(n_ct))
            return F_CROSS_CAR;
        else if (e_wt == W_GREEN && e_ct != C_RED)
            return F_E_WALK;
        else if (n_wt == W_GREEN && n_ct != C_RED)
            return F_N_WALK;
        else if (car_illegal(e_ct) || car_illegal(n_ct) || e_wt == W_ILLEGAL || n_wt == W_ILLEGAL)
            return F_ILLEGAL;
        else
            return F_NONE;
    endfunction

endpackage

// File: rtl/lamp_blink_tick.sv
// Blink prescaler: counts TICK_DIV clocks per half-period, pulses tick on the last one and toggles phase.
// restart puts the count at zero with phase high so the first blink cycle is lit.
module lamp_blink_tick #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    input  logic enable,
    output logic tick,
    output logic phase
);

    localparam int CW = $clog2(TICK_DIV + 1);

    logic [CW-1:0] tick_cnt;

    assign tick = enable && (tick_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            phase    <= 1'b0;
        end else if (restart) begin
            tick_cnt <= '0;
            phase    <= 1'b1;
        end else if (tick) begin
            tick_cnt <= '0;
            phase    <= ~phase;
        end else if (enable) begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/lamp_safety_monitor.sv
// Registers the E/N lamp codes to the pins and latches a fault on persistent conflicting indications.
// While faulted, car lamps flash yellow and walker lamps go dark until an operator clear is accepted.
module lamp_safety_monitor
    import lamp_safety_monitor_pkg::*;
#(
    parameter int TICK_DIV         = 25000000,
    parameter int CONFLICT_CYCLES  = 2,
    parameter int CLEAR_HOLD_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] i_e_ct,
    input  logic [1:0] i_e_wt,
    input  logic [3:0] i_n_ct,
    input  logic [1:0] i_n_wt,
    input  logic       i_clear,
    output logic [3:0] o_e_ct,
    output logic [1:0] o_e_wt,
    output logic [3:0] o_n_ct,
    output logic [1:0] o_n_wt,
    output logic       o_fault,
    output logic [2:0] o_fault_code
);

    localparam int PW = $clog2(CONFLICT_CYCLES + 1);
    localparam int HW = $clog2(CLEAR_HOLD_TICKS + 1);

    monitor_state_t state, state_next;

    logic [PW-1:0] persist_cnt;
    logic [HW-1:0] hold_cnt;
    logic [3:0]    e_ct_q, n_ct_q;
    logic [1:0]    e_wt_q, n_wt_q;
    logic [2:0]    viol;
    logic          any_viol, trip, clear_ok, hold_done, faulted;
    logic          tick, phase;

    assign viol      = violation_code(i_e_ct, i_e_wt, i_n_ct, i_n_wt);
    assign any_viol  = (viol != F_NONE);
    assign trip      = (state == MONITOR) && any_viol && (persist_cnt == PW'(CONFLICT_CYCLES - 1));
    assign clear_ok  = (state == FAULT_CLEARABLE) && i_clear && !any_viol;
    assign hold_done = (state == FAULT_HOLD) && tick && (hold_cnt == HW'(CLEAR_HOLD_TICKS - 1));
    assign faulted   = (state != MONITOR);

    lamp_blink_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_blink (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (trip),
        .enable  (faulted),
        .tick    (tick),
        .phase   (phase)
    );

    always_comb begin
        state_next = state;
        case (state)
            MONITOR:         if (trip)      state_next = FAULT_HOLD;
            FAULT_HOLD:      if (hold_done) state_next = FAULT_CLEARABLE;
            FAULT_CLEARABLE: if (clear_ok)  state_next = MONITOR;
            default:                        state_next = MONITOR;
        endcase
    end

    // The fault code is sticky across a clear; only a new trip or reset replaces it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= MONITOR;
            persist_cnt  <= '0;
            hold_cnt     <= '0;
            o_fault_code <= F_NONE;
            e_ct_q       <= C_NONE;
            e_wt_q       <= W_NONE;
            n_ct_q       <= C_NONE;
            n_wt_q       <= W_NONE;
        end else begin
            state  <= state_next;
            e_ct_q <= i_e_ct;
            e_wt_q <= i_e_wt;
            n_ct_q <= i_n_ct;
            n_wt_q <= i_n_wt;

            if (clear_ok || !any_viol)
                persist_cnt <= '0;
            else if (persist_cnt != PW'(CONFLICT_CYCLES))
                persist_cnt <= persist_cnt + PW'(1);

            if (trip || clear_ok)
                hold_cnt <= '0;
            else if (state == FAULT_HOLD && tick)
                hold_cnt <= hold_cnt + HW'(1);

            if (trip)
                o_fault_code <= viol;
        end
    end

    assign o_fault = faulted;
    assign o_e_ct  = faulted ? (phase ? C_YELLOW : C_NONE) : e_ct_q;
    assign o_n_ct  = faulted ? (phase ? C_YELLOW : C_NONE) : n_ct_q;
    assign o_e_wt  = faulted ? W_NONE : e_wt_q;
    assign o_n_wt  = faulted ? W_NONE : n_wt_q;

endmodule

// File: tb/tb_lamp_safety_monitor.sv
// Self-checking bench: directed scenarios then randomized lamp codes, all compared each cycle
// against a behavioural model that tracks fault age in clock cycles.
module tb_lamp_safety_monitor;

    localparam int TD = 4;
    localparam int CC = 2;
    localparam int HT = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] i_e_ct = '0;
    logic [1:0] i_e_wt = '0;
    logic [3:0] i_n_ct = '0;
    logic [1:0] i_n_wt = '0;
    logic       i_clear = 1'b0;
    logic [3:0] o_e_ct, o_n_ct;
    logic [1:0] o_e_wt, o_n_wt;
    logic       o_fault;
    logic [2:0] o_fault_code;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model state: fault flag, 1-based cycle index inside the fault, violation run length.
    bit         modelFault = 0;
    int         modelAge   = 0;
    int         modelRun   = 0;
    int         modelCode  = 0;
    logic [3:0] prevEct = '0, prevNct = '0;
    logic [1:0] prevEwt = '0, prevNwt = '0;

    lamp_safety_monitor #(
        .TICK_DIV         (TD),
        .CONFLICT_CYCLES  (CC),
        .CLEAR_HOLD_TICKS (HT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_e_ct       (i_e_ct),
        .i_e_wt       (i_e_wt),
        .i_n_ct       (i_n_ct),
        .i_n_wt       (i_n_wt),
        .i_clear      (i_clear),
        .o_e_ct       (o_e_ct),
        .o_e_wt       (o_e_wt),
        .o_n_ct       (o_n_ct),
        .o_n_wt       (o_n_wt),
        .o_fault      (o_fault),
        .o_fault_code (o_fault_code)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int refViolation(input logic [3:0] ect, input logic [1:0] ewt,
                                        input logic [3:0] nct, input logic [1:0] nwt);
        bit eMove, nMove;
        int eBits, nBits;
        eMove = ect inside {4'b0001, 4'b0010, 4'b0100};
        nMove = nct inside {4'b0001, 4'b0010, 4'b0100};
        eBits = 0;
        nBits = 0;
        for (int b = 0; b < 4; b++) begin
            eBits += int'(ect[b]);
            nBits += int'(nct[b]);
        end
        if (eMove && nMove) return 1;
        if (ewt == 2'b01 && ect != 4'b1000) return 2;
        if (nwt == 2'b01 && nct != 4'b1000) return 3;
        if (eBits > 1 || nBits > 1 || ewt == 2'b11 || nwt == 2'b11) return 4;
        return 0;
    endfunction

    task automatic modelStep(input logic [3:0] ect, input logic [1:0] ewt, input logic [3:0] nct,
                             input logic [1:0] nwt, input logic clr, input logic rstn);
        int v;
        bit cleared;
        cleared = 0;
        if (!rstn) begin
            modelFault = 0;
            modelAge   = 0;
            modelRun   = 0;
            modelCode  = 0;
            prevEct = '0; prevEwt = '0; prevNct = '0; prevNwt = '0;
        end else begin
            v = refViolation(ect, ewt, nct, nwt);
            if (!modelFault) begin
                if (v != 0 && modelRun + 1 >= CC) begin
                    modelFault = 1;
                    modelAge   = 1;
                    modelCode  = v;
                end
            end else if (modelAge > TD * HT && clr && v == 0) begin
                modelFault = 0;
                modelAge   = 0;
                cleared    = 1;
            end else begin
                modelAge++;
            end
            if (cleared || v == 0) modelRun = 0;
            else if (modelRun < CC) modelRun++;
            prevEct = ect; prevEwt = ewt; prevNct = nct; prevNwt = nwt;
        end
    endtask

    task automatic checkAllOutputs();
        logic [3:0] expCar;
        if (modelFault) begin
            expCar = (((modelAge - 1) / TD) % 2 == 0) ? 4'b0100 : 4'b0000;
            checkOutput("eCar", 32'(o_e_ct), 32'(expCar));
            checkOutput("nCar", 32'(o_n_ct), 32'(expCar));
            checkOutput("eWalk", 32'(o_e_wt), 32'd0);
            checkOutput("nWalk", 32'(o_n_wt), 32'd0);
        end else begin
            checkOutput("eCar", 32'(o_e_ct), 32'(prevEct));
            checkOutput("nCar", 32'(o_n_ct), 32'(prevNct));
            checkOutput("eWalk", 32'(o_e_wt), 32'(prevEwt));
            checkOutput("nWalk", 32'(o_n_wt), 32'(prevNwt));
        end
        checkOutput("fault", 32'(o_fault), 32'(modelFault));
        checkOutput("faultCode", 32'(o_fault_code), 32'(modelCode));
    endtask

    // Drives one cycle of inputs, advances the model on the edge and checks #1 afterwards.
    task automatic applyStimulus(input logic [3:0] ect, input logic [1:0] ewt, input logic [3:0] nct,
                                 input logic [1:0] nwt, input logic clr, input logic rstn);
        i_e_ct = ect; i_e_wt = ewt; i_n_ct = nct; i_n_wt = nwt; i_clear = clr; reset_n = rstn;
        @(posedge clk);
        modelStep(ect, ewt, nct, nwt, clr, rstn);
        #1;
        checkAllOutputs();
    endtask

    task automatic runCycles(input int n, input logic [3:0] ect, input logic [1:0] ewt,
                             input logic [3:0] nct, input logic [1:0] nwt, input logic clr);
        for (int i = 0; i < n; i++) applyStimulus(ect, ewt, nct, nwt, clr, 1'b1);
    endtask

    task automatic genLegal(output logic [3:0] ect, output logic [1:0] ewt,
                            output logic [3:0] nct, output logic [1:0] nwt);
        logic [3:0] moveCar;
        logic [1:0] stopWalk;
        int sel;
        sel = $urandom_range(0, 3);
        case ($urandom_range(0, 3))
            0: moveCar = 4'b0001;
            1: moveCar = 4'b0010;
            2: moveCar = 4'b0100;
            default: moveCar = 4'b1000;
        endcase
        case ($urandom_range(0, 2))
            0: stopWalk = 2'b00;
            1: stopWalk = 2'b01;
            default: stopWalk = 2'b10;
        endcase
        if (sel == 0) begin
            ect = 4'b0000; ewt = 2'b00; nct = 4'b0000; nwt = 2'b00;
        end else if (sel == 1) begin
            ect = moveCar; ewt = 2'b10; nct = 4'b1000; nwt = stopWalk;
        end else begin
            ect = 4'b1000; ewt = stopWalk; nct = moveCar; nwt = 2'b10;
        end
    endtask

    initial begin
        logic [3:0] ect, nct;
        logic [1:0] ewt, nwt;

        $display("[TB] start");
        applyStimulus(4'b0000, 2'b00, 4'b0000, 2'b00, 1'b0, 1'b0);
        applyStimulus(4'b1000, 2'b01, 4'b0001, 2'b10, 1'b0, 1'b0);
        checkOutput("resetCar", 32'(o_e_ct), 32'd0);

        runCycles(10, 4'b1000, 2'b01, 4'b0001, 2'b10, 1'b0);
        checkOutput("passThroughFault", 32'(o_fault), 32'd0);
        checkOutput("passThroughECar", 32'(o_e_ct), 32'h8);

        runCycles(1, 4'b0001, 2'b10, 4'b0100, 2'b10, 1'b0);
        runCycles(3, 4'b1000, 2'b10, 4'b0001, 2'b10, 1'b0);
        checkOutput("glitchNoTrip", 32'(o_fault), 32'd0);
        runCycles(2, 4'b0001, 2'b10, 4'b0100, 2'b10, 1'b0);
        checkOutput("crossCarTrip", 32'(o_fault), 32'd1);
        checkOutput("crossCarCode", 32'(o_fault_code), 32'd1);
        runCycles(20, 4'b1000, 2'b10, 4'b0001, 2'b10, 1'b1);
        checkOutput("crossCarCleared", 32'(o_fault), 32'd0);

        runCycles(2, 4'b1000, 2'b10, 4'b0001, 2'b01, 1'b0);
        checkOutput("walkCode", 32'(o_fault_code), 32'd3);
        checkOutput("walkBlinkOn", 32'(o_n_ct), 32'h4);
        runCycles(6, 4'b1000, 2'b10, 4'b0001, 2'b10, 1'b0);
        runCycles(1, 4'b1000, 2'b10, 4'b0001, 2'b10, 1'b1);
        checkOutput("clearTooEarly", 32'(o_fault), 32'd1);
        checkOutput("walkBlinkOff", 32'(o_e_ct), 32'h0);
        runCycles(8, 4'b1000, 2'b10, 4'b0001, 2'b10, 1'b0);
        runCycles(2, 4'b0001, 2'b10, 4'b0100, 2'b10, 1'b1);
        checkOutput("clearWhileViolating", 32'(o_fault), 32'd1);
        checkOutput("codeNotOverwritten", 32'(o_fault_code), 32'd3);
        runCycles(1, 4'b1000, 2'b10, 4'b0001, 2'b10, 1'b1);
        checkOutput("clearAccepted", 32'(o_fault), 32'd0);
        checkOutput("codeRetained", 32'(o_fault_code), 32'd3);
        runCycles(1, 4'b0001, 2'b10, 4'b1000, 2'b01, 1'b0);

        runCycles(2, 4'b0011, 2'b10, 4'b1000, 2'b10, 1'b0);
        checkOutput("illegalCode", 32'(o_fault_code), 32'd4);
        runCycles(5, 4'b1000, 2'b10, 4'b0001, 2'b10, 1'b0);
        applyStimulus(4'b1000, 2'b10, 4'b0001, 2'b10, 1'b0, 1'b0);
        checkOutput("midFaultReset", 32'(o_fault), 32'd0);
        checkOutput("midFaultResetCode", 32'(o_fault_code), 32'd0);
        runCycles(3, 4'b1000, 2'b10, 4'b0001, 2'b10, 1'b0);

        runCycles(2, 4'b0001, 2'b11, 4'b0100, 2'b10, 1'b0);
        checkOutput("priorityCode", 32'(o_fault_code), 32'd1);
        runCycles(20, 4'b1000, 2'b10, 4'b0001, 2'b10, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                ect = 4'($urandom_range(0, 15)); ewt = 2'($urandom_range(0, 3));
                nct = 4'($urandom_range(0, 15)); nwt = 2'($urandom_range(0, 3));
            end else begin
                genLegal(ect, ewt, nct, nwt);
            end
            applyStimulus(ect, ewt, nct, nwt, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 299) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
